// File: rtl/conv_control_unit.sv
// -----------------------------------------------------------------------------
// conv_control_unit
//   Layer sequencer for a convolution datapath. One start pulse runs a layer
//   through four phases:
//     IDLE -> LOAD_KERNEL -> STREAM -> DRAIN -> DONE -> IDLE
//   LOAD_KERNEL : counts Channel_size kernel BRAM words.
//   STREAM      : walks the input image (col, then row, then channel) once per
//                 accepted input beat and advances the output BRAM A address.
//   DRAIN       : counts Image_size^2/4 output beats on BRAM B.
//   DONE        : one-cycle done pulse.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start                      layer start, sizes sampled in the same cycle
//   Image_size / Channel_size  layer geometry (8 / 9 bits)
//   kernel_wr_valid            one kernel word written this cycle
//   in_fire / out_fire         accepted input / output stream beats
//   Load_kernel_BRAM           high while kernel words are being loaded
//   kernel_BRAM_counter_out    kernel word index, then channel index
//   window_BRAM_counter_out    low 7 bits of the column counter
//   a_/b_output_BRAM_counter_out  output BRAM addresses
//   in_row_counter / in_col_counter  current input pixel position
//   busy, done, cfg_err        status (all registered)
//
// Build option
//   CONV_CTRL_ERR_EN : reject starts with unsupported sizes and flag cfg_err.
//                      Without it, cfg_err is held 0 and sizes are used as given.
// -----------------------------------------------------------------------------
module conv_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  Image_size,
  input  logic [8:0]  Channel_size,
  input  logic        kernel_wr_valid,
  input  logic        in_fire,
  input  logic        out_fire,
  output logic        Load_kernel_BRAM,
  output logic [7:0]  kernel_BRAM_counter_out,
  output logic [6:0]  window_BRAM_counter_out,
  output logic [13:0] a_output_BRAM_counter_out,
  output logic [13:0] b_output_BRAM_counter_out,
  output logic [7:0]  in_row_counter,
  output logic [7:0]  in_col_counter,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  img_q, img_d;
  logic [8:0]  ch_q, ch_d;
  logic [7:0]  kcnt_q, kcnt_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;
  logic [13:0] a_q, a_d;
  logic [13:0] b_q, b_d;
  logic        err_q, err_d;
  logic        load_q, busy_q, done_q;

  logic [14:0] sq_s;
  logic [14:0] a_last_s;
  logic [14:0] b_last_s;
  logic [8:0]  ch_last_s;
  logic [7:0]  img_last_s;
  logic        cfg_ok_s;

`ifdef CONV_CTRL_ERR_EN
  function automatic logic sizes_legal(input logic [7:0] img, input logic [8:0] ch);
    logic img_ok;
    logic ch_ok;
    case (img)
      8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128: img_ok = 1'b1;
      default:                                 img_ok = 1'b0;
    endcase
    case (ch)
      9'd64, 9'd128, 9'd256: ch_ok = 1'b1;
      default:               ch_ok = 1'b0;
    endcase
    return img_ok & ch_ok;
  endfunction

  assign cfg_ok_s = sizes_legal(Image_size, Channel_size);
`else
  assign cfg_ok_s = 1'b1;
`endif

  // Image_size^2 reaches 16384, so the product is formed in 15 bits before
  // any terminal-count compare against the 14-bit address counters.
  assign sq_s       = {7'd0, img_q} * {7'd0, img_q};
  assign a_last_s   = sq_s - 15'd1;
  assign b_last_s   = (sq_s >> 2) - 15'd1;
  assign ch_last_s  = ch_q - 9'd1;
  assign img_last_s = img_q - 8'd1;

  // Next-state and next-counter logic for the layer sequencer.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    ch_d    = ch_q;
    kcnt_d  = kcnt_q;
    row_d   = row_q;
    col_d   = col_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok_s) begin
            img_d   = Image_size;
            ch_d    = Channel_size;
            kcnt_d  = 8'd0;
            row_d   = 8'd0;
            col_d   = 8'd0;
            a_d     = 14'd0;
            b_d     = 14'd0;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (kernel_wr_valid) begin
          // Last kernel word: counter restarts as the channel index for STREAM.
          if ({1'b0, kcnt_q} == ch_last_s) begin
            kcnt_d  = 8'd0;
            state_d = S_STREAM;
          end else begin
            kcnt_d = kcnt_q + 8'd1;
          end
        end
      end
      S_STREAM: begin
        if (in_fire) begin
          if ({1'b0, a_q} == a_last_s) begin
            a_d = 14'd0;
          end else begin
            a_d = a_q + 14'd1;
          end
          if (col_q == img_last_s) begin
            col_d = 8'd0;
            if (row_q == img_last_s) begin
              row_d  = 8'd0;
              kcnt_d = kcnt_q + 8'd1;
              if ({1'b0, kcnt_q} == ch_last_s) begin
                state_d = S_DRAIN;
              end
            end else begin
              row_d = row_q + 8'd1;
            end
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          b_d = b_q + 14'd1;
          if ({1'b0, b_q} == b_last_s) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and registered-status flops; flags follow the next state so
  // they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      img_q   <= 8'd0;
      ch_q    <= 9'd0;
      kcnt_q  <= 8'd0;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      a_q     <= 14'd0;
      b_q     <= 14'd0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      ch_q    <= ch_d;
      kcnt_q  <= kcnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      load_q  <= (state_d == S_LOAD);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign Load_kernel_BRAM          = load_q;
  assign kernel_BRAM_counter_out   = kcnt_q;
  assign window_BRAM_counter_out   = col_q[6:0];
  assign a_output_BRAM_counter_out = a_q;
  assign b_output_BRAM_counter_out = b_q;
  assign in_row_counter            = row_q;
  assign in_col_counter            = col_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign cfg_err                   = err_q;

endmodule

// File: doc/conv_control_unit.md
CONV_CONTROL_UNIT -- requirements
Module: conv_control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  one-cycle layer start; Image_size/Channel_size sampled at this cycle.
REQ-004 SHALL have ports: Image_size  in  8  4/8/16/32/64/128. Channel_size  in  9  64/128/256.
REQ-005 SHALL have ports: kernel_wr_valid  in  1  one kernel BRAM word presented this cycle.
REQ-006 SHALL have ports: in_fire  in  1  s_axis_tvalid&s_axis_tready of datapath. out_fire  in  1  m_axis_tvalid&m_axis_tready.
REQ-007 SHALL have ports: Load_kernel_BRAM  out  1. kernel_BRAM_counter_out  out  8. window_BRAM_counter_out  out  7.
REQ-008 SHALL have ports: a_output_BRAM_counter_out  out  14. b_output_BRAM_counter_out  out  14. in_row_counter  out  8. in_col_counter  out  8.
REQ-009 SHALL have ports: busy  out  1. done  out  1  one-cycle pulse. cfg_err  out  1 (only meaningful with CONV_CTRL_ERR_EN).

Function
REQ-010 SHALL implement FSM IDLE -> LOAD_KERNEL -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-011 IDLE: start=1 SHALL latch sizes, clear all counters, enter LOAD_KERNEL next cycle; start outside IDLE SHALL be ignored.
REQ-012 LOAD_KERNEL: Load_kernel_BRAM=1; kernel_BRAM_counter_out SHALL increment by 1 per kernel_wr_valid, modulo 256.
REQ-013 LOAD_KERNEL SHALL exit to STREAM in the cycle after the Channel_size-th kernel_wr_valid; kernel counter SHALL be 0 on entry to STREAM.
REQ-014 STREAM: per in_fire, in_col_counter SHALL increment; at Image_size-1 it SHALL wrap to 0 and in_row_counter SHALL increment.
REQ-015 window_BRAM_counter_out SHALL equal in_col_counter[6:0] at all times.
REQ-016 a_output_BRAM_counter_out SHALL increment per in_fire, wrapping to 0 after Image_size*Image_size-1.
REQ-017 On in_fire at row=col=Image_size-1, row SHALL wrap to 0 and kernel_BRAM_counter_out SHALL increment (channel index).
REQ-018 On the in_fire completing channel Channel_size-1, FSM SHALL enter DRAIN; no counter other than b SHALL move in DRAIN.
REQ-019 DRAIN: b_output_BRAM_counter_out SHALL increment per out_fire; on out_fire at Image_size*Image_size/4-1 FSM SHALL enter DONE.
REQ-020 out_fire outside DRAIN and in_fire outside STREAM SHALL be ignored; kernel_wr_valid outside LOAD_KERNEL SHALL be ignored.
REQ-021 DONE SHALL last exactly one cycle with done=1, then IDLE; counters SHALL hold final values until next start.
REQ-022 busy SHALL be 1 in LOAD_KERNEL, STREAM, DRAIN, DONE; 0 in IDLE.
REQ-023 All outputs SHALL be registered; counter update visible the cycle after the qualifying input.
REQ-024 Size products SHALL be computed at full width (Image_size^2 up to 16384 in 15 bits) before compare.

Reset
REQ-025 reset=1 SHALL force IDLE and all outputs to 0 next edge, including mid-operation; reset SHALL take priority over start.
REQ-026 First start SHALL be accepted in the cycle after reset deasserts.

Configuration
REQ-027 With CONV_CTRL_ERR_EN defined: start with Image_size not in {4,8,16,32,64,128} or Channel_size not in {64,128,256} SHALL stay IDLE and set cfg_err=1 until next legal start or reset.
REQ-028 Without CONV_CTRL_ERR_EN: no check, cfg_err tied 0, sizes used as given.

Verification
REQ-029 Reset, start Image_size=4 Channel_size=64, 64 kernel_wr_valid -> kernel counter 0..63 then 0, STREAM entered, Load_kernel_BRAM drops.
REQ-030 STREAM 4x4x64, in_fire every cycle -> col 0..3 wrap, row 0..3 wrap, a counter 0..15 wrap, DRAIN after 1024 fires.
REQ-031 DRAIN Image_size=4 with out_fire gapped -> b counter 0..3, done single pulse after 4th out_fire, then IDLE, busy=0.
REQ-032 Assert reset during STREAM at row=2 col=1 -> all outputs 0 next cycle, state IDLE, new start accepted.
REQ-033 start while busy, stray in_fire in LOAD_KERNEL, out_fire in STREAM -> no state or counter change.
REQ-034 With CONV_CTRL_ERR_EN: start Image_size=5 -> cfg_err=1, busy=0; then legal start -> cfg_err=0, busy=1.
